// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern controller.
//   mode_e          : pattern mode (SHIFT rotates a one-hot, FLASH blinks all LEDs)
//   SEL_R/G/B       : one-hot colour-bank select codes
//   DEF_LIM0..3     : default prescaler periods for the four speed settings
//   cnt_width()     : prescaler counter width needed for the largest period
package led_ctrl_pkg;

  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_FLASH = 1'b1
  } mode_e;

  localparam logic [2:0] SEL_R = 3'b100;
  localparam logic [2:0] SEL_G = 3'b010;
  localparam logic [2:0] SEL_B = 3'b001;

  localparam int DEF_LIM0 = 2**23;
  localparam int DEF_LIM1 = 2**24;
  localparam int DEF_LIM2 = 2**25;
  localparam int DEF_LIM3 = 2**26;

  // The counter only ever holds LIM-1, so $clog2(max LIM) bits suffice.
  function automatic int cnt_width(input int l0, input int l1, input int l2, input int l3);
    int m;
    m = l0;
    if (l1 > m) m = l1;
    if (l2 > m) m = l2;
    if (l3 > m) m = l3;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector, one bit per input.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   async_i : raw asynchronous inputs
//   rise_o  : one-cycle pulse per rising edge of each synchronized input
// A level change on async_i shows up on rise_o after two clock edges, so a
// register fed by rise_o reflects it on the third edge. A held input yields a
// single pulse.
module btn_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q;

  // NOTE: the synchronizer stages are cleared on reset too, so a button held
  // through reset does not produce a spurious edge the moment reset releases
  // unless it is genuinely high afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make the three stages shift in
      // parallel; blocking ones would collapse the chain into a single flop.
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: generates a rotating one-hot or flashing pattern at
// a switch-selected rate and a one-hot colour-bank select driven by buttons.
//   i_clk       : clock
//   i_reset     : synchronous active-low reset
//   i_sw        : [0] run enable, [2:1] speed, [3] direction (0 left, 1 right)
//   i_btn       : raw buttons, [0] mode toggle, [1] red, [2] green, [3] blue
//   o_led       : current pattern
//   o_color_sel : one-hot colour select (100 R, 010 G, 001 B)
//   o_mode      : 0 SHIFT, 1 FLASH
//   o_tick      : one-cycle pulse following each pattern update
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int COLOR  = 3,
  parameter int N_SW   = 4,
  parameter int N_BTN  = 4,
  parameter int LIM0   = DEF_LIM0,
  parameter int LIM1   = DEF_LIM1,
  parameter int LIM2   = DEF_LIM2,
  parameter int LIM3   = DEF_LIM3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_SW-1:0]   i_sw,
  input  logic [N_BTN-1:0]  i_btn,
  output logic [N_LEDS-1:0] o_led,
  output logic [COLOR-1:0]  o_color_sel,
  output logic              o_mode,
  output logic              o_tick
);

  localparam int CW = cnt_width(LIM0, LIM1, LIM2, LIM3);
  localparam logic [N_LEDS-1:0] LED_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};

  // Button edges.
  logic [N_BTN-1:0] btn_rise;

  btn_edge_sync #(.WIDTH(N_BTN)) u_btn_sync (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .async_i(i_btn),
    .rise_o (btn_rise)
  );

  // Switches only need level synchronization; speed_q remembers the previous
  // synchronized speed so a change can restart the prescaler.
  logic [N_SW-1:0] sw_meta_q, sw_q;
  logic [1:0]      speed_q;

  logic            run_en, dir_right, speed_chg, mode_tgl;
  logic [1:0]      speed;
  logic [CW-1:0]   lim_m1;

  assign run_en    = sw_q[0];
  assign speed     = sw_q[2:1];
  assign dir_right = sw_q[3];
  assign speed_chg = (speed != speed_q);
  assign mode_tgl  = btn_rise[0];

  always_comb begin
    case (speed)
      2'd0:    lim_m1 = CW'(LIM0 - 1);
      2'd1:    lim_m1 = CW'(LIM1 - 1);
      2'd2:    lim_m1 = CW'(LIM2 - 1);
      default: lim_m1 = CW'(LIM3 - 1);
    endcase
  end

  // Pattern FSM and prescaler.
  mode_e             mode_q, mode_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [COLOR-1:0]  color_q, color_d;
  logic              tick_q, tick_d;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the branches below leaves one unassigned (which infers a latch).
    mode_d  = mode_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    tick_d  = 1'b0;

    // Red beats green beats blue when edges coincide.
    if (btn_rise[1])      color_d = COLOR'(SEL_R);
    else if (btn_rise[2]) color_d = COLOR'(SEL_G);
    else if (btn_rise[3]) color_d = COLOR'(SEL_B);

    if (mode_tgl) begin
      // A mode toggle reloads the pattern and restarts the period; a tick
      // falling on the same edge is discarded.
      cnt_d = '0;
      case (mode_q)
        MODE_SHIFT: begin
          mode_d = MODE_FLASH;
          led_d  = '1;
        end
        default: begin
          mode_d = MODE_SHIFT;
          led_d  = LED_INIT;
        end
      endcase
    end else if (speed_chg) begin
      cnt_d = '0;
    end else if (run_en) begin
      if (cnt_q == lim_m1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          MODE_SHIFT: led_d = dir_right ? {led_q[0], led_q[N_LEDS-1:1]}
                                        : {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
          default:    led_d = (led_q == '1) ? '0 : '1;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sw_meta_q <= '0;
      sw_q      <= '0;
      speed_q   <= '0;
      mode_q    <= MODE_SHIFT;
      led_q     <= LED_INIT;
      cnt_q     <= '0;
      color_q   <= COLOR'(SEL_R);
      tick_q    <= 1'b0;
    end else begin
      sw_meta_q <= i_sw;
      sw_q      <= sw_meta_q;
      speed_q   <= speed;
      mode_q    <= mode_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      tick_q    <= tick_d;
    end
  end

  assign o_led       = led_q;
  assign o_color_sel = color_q;
  assign o_mode      = (mode_q == MODE_FLASH);
  assign o_tick      = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw, btn;
  logic [3:0] led;
  logic [2:0] color;
  logic       mode, tick;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .N_LEDS(4), .COLOR(3), .N_SW(4), .N_BTN(4),
    .LIM0(4), .LIM1(8), .LIM2(16), .LIM3(32)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_sw       (sw),
    .i_btn      (btn),
    .o_led      (led),
    .o_color_sel(color),
    .o_mode     (mode),
    .o_tick     (tick)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the pattern is an LED index (SHIFT) or an on/off phase
  // (FLASH); raw input samples are kept per clock edge so that synchronizer
  // latency is just "look back N edges".
  int         lims [4] = '{4, 8, 16, 32};
  int         m_cnt, m_pos;
  bit         m_flash, m_flash_on, m_tick;
  logic [2:0] m_color;
  logic [3:0] bh [1:3];   // bh[k] = raw buttons sampled k edges ago
  logic [3:0] sh [1:3];   // sh[k] = raw switches sampled k edges ago

  function automatic logic [3:0] exp_led();
    if (m_flash) return m_flash_on ? 4'hF : 4'h0;
    return 4'(1 << m_pos);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] ev;
    int spd, spd_prev, lim;
    if (!rst_n) begin
      m_cnt = 0; m_pos = 0; m_flash = 0; m_flash_on = 0; m_tick = 0;
      m_color = 3'b100;
      for (int i = 1; i <= 3; i++) begin bh[i] = '0; sh[i] = '0; end
      return;
    end
    ev       = bh[2] & ~bh[3];
    spd      = int'(sh[2][2:1]);
    spd_prev = int'(sh[3][2:1]);
    lim      = lims[spd];
    m_tick   = 0;
    if (ev[1])      m_color = 3'b100;
    else if (ev[2]) m_color = 3'b010;
    else if (ev[3]) m_color = 3'b001;
    if (ev[0]) begin
      m_flash    = !m_flash;
      m_cnt      = 0;
      m_pos      = 0;
      m_flash_on = 1;
    end else if (spd != spd_prev) begin
      m_cnt = 0;
    end else if (sh[2][0]) begin
      if (m_cnt == lim - 1) begin
        m_cnt  = 0;
        m_tick = 1;
        if (m_flash) m_flash_on = !m_flash_on;
        else         m_pos = (m_pos + (sh[2][3] ? 3 : 1)) % 4;
      end else begin
        m_cnt++;
      end
    end
    bh[3] = bh[2]; bh[2] = bh[1]; bh[1] = btn;
    sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sw;
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led",   32'(led),   32'(exp_led()));
    check("color", 32'(color), 32'(m_color));
    check("mode",  32'(mode),  32'(m_flash));
    check("tick",  32'(tick),  32'(m_tick));
  endtask

  // Steps until o_tick is seen or the bound runs out; n is the step count.
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < bound);
  endtask

  task automatic wait_cnt(input int value);
    for (int i = 0; i < 40 && m_cnt != value; i++) step();
  endtask

  int         n;
  int         changes;
  logic [2:0] prev_color;
  logic [3:0] frozen;

  initial begin
    rst_n = 1'b0; sw = '0; btn = '0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    step();
    check("rst_led",   32'(led),   32'h1);
    check("rst_color", 32'(color), 32'h4);
    check("rst_mode",  32'(mode),  32'h0);
    check("rst_tick",  32'(tick),  32'h0);

    // Rotate left at speed 0.
    sw = 4'b0001;
    wait_tick(20, n);
    check("left_first", 32'(led), 32'h2);
    wait_tick(20, n);
    check("left_gap", 32'(n), 32'd4);
    check("left_0100", 32'(led), 32'h4);

    // Direction flips to right while showing 0100.
    sw = 4'b1001;
    wait_tick(20, n);
    check("right_0010", 32'(led), 32'h2);
    wait_tick(20, n);
    check("right_0001", 32'(led), 32'h1);
    wait_tick(20, n);
    check("right_wrap", 32'(led), 32'h8);

    // Green and blue together: green wins, three edges later.
    btn = 4'b1100;
    step();
    btn = 4'b0000;
    step();
    check("gb_pending", 32'(color), 32'h4);
    step();
    check("gb_green", 32'(color), 32'h2);
    step();

    // Blue held for 50 cycles gives exactly one update.
    btn = 4'b1000;
    prev_color = color;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (color !== prev_color) changes++;
      prev_color = color;
    end
    btn = 4'b0000;
    check("blue_once", 32'(changes), 32'd1);
    check("blue_sel", 32'(color), 32'h1);

    // Mode toggle lands on the edge that would have ticked.
    wait_cnt(1);
    btn = 4'b0001;
    step();
    btn = 4'b0000;
    step();
    step();
    check("tgl_mode", 32'(mode), 32'h1);
    check("tgl_led",  32'(led),  32'hF);
    check("tgl_tick", 32'(tick), 32'h0);
    wait_tick(20, n);
    check("flash_gap", 32'(n), 32'd4);
    check("flash_off", 32'(led), 32'h0);
    wait_tick(20, n);
    check("flash_on", 32'(led), 32'hF);

    // Speed 0 -> 1 while the count is at 2.
    wait_cnt(0);
    sw = 4'b1011;
    step(); step(); step();
    wait_tick(30, n);
    check("speed_restart", 32'(n), 32'd8);

    // Run enable dropped: pattern and tick freeze.
    sw = 4'b1010;
    step(); step();
    frozen = led;
    for (int i = 0; i < 20; i++) begin
      step();
      check("frz_tick", 32'(tick), 32'h0);
      check("frz_led",  32'(led),  32'(frozen));
    end
    sw = 4'b1011;
    for (int i = 0; i < 30; i++) step();

    // Reset in the middle of a pattern.
    rst_n = 1'b0;
    step();
    check("mid_rst_led",   32'(led),   32'h1);
    check("mid_rst_color", 32'(color), 32'h4);
    check("mid_rst_mode",  32'(mode),  32'h0);
    check("mid_rst_tick",  32'(tick),  32'h0);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        sw = {4'($urandom_range(0, 7)), 1'b0} | 4'($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) btn = 4'($urandom);
      else if ($urandom_range(0, 2) == 0) btn = '0;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
